// File: rtl/prog_mem.sv
// CPU main memory with a front-panel byte loader.
// CPU and loader share one write port; load mode (ld_en) decides which one owns it.
module prog_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic [7:0]        wdata,
  input  logic              read,
  input  logic              write,
  output logic [7:0]        rdata,
  input  logic              ld_en,
  input  logic              ld_strobe,
  input  logic [7:0]        ld_data,
  output logic [ADDR_W-1:0] ld_ptr,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_full,
  output logic [7:0]        ld_view
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, FULL} state_t;

  logic [7:0]        mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              strobe_q;
  logic              rise;
  logic              ld_we;
  logic              cpu_we;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
  logic              unused_addr_hi;

  // Upper address bits alias onto the implemented range.
  assign addr_lo        = addr[ADDR_W-1:0];
  assign unused_addr_hi = ^addr[15:ADDR_W];

  assign rise    = ld_strobe & ~strobe_q;
  assign cnt_inc = cnt_q + 1'b1;
  assign cpu_we  = write & ~ld_en;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    ld_we   = 1'b0;
    if (state_q != IDLE && !ld_en) begin
      // Leaving load mode keeps pointer/count/full on display.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_en) begin
            state_d = WAIT;
            ptr_d   = '0;
            cnt_d   = '0;
            full_d  = 1'b0;
          end
        end
        WAIT: begin
          if (rise) begin
            ld_we = 1'b1;
            ptr_d = ptr_q + 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == DEPTH_CNT) begin
              state_d = FULL;
              full_d  = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (!ld_strobe) state_d = WAIT;
        end
        FULL: begin
          state_d = FULL;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      strobe_q <= ld_strobe;
    end
  end

  // ld_we and cpu_we are exclusive: the loader writes only while ld_en=1.
  assign mem_waddr = ld_we ? ptr_q : addr_lo;
  assign mem_wdata = ld_we ? ld_data : wdata;

  // The array is deliberately not reset so a loaded program survives reset.
  always_ff @(posedge clk) begin
    if (!rst && (ld_we || cpu_we)) mem[mem_waddr] <= mem_wdata;
  end

  assign rdata    = (read && !ld_en) ? mem[addr_lo] : 8'h00;
  assign ld_view  = mem[ptr_q];
  assign ld_ptr   = ptr_q;
  assign ld_count = cnt_q;
  assign ld_full  = full_q;

endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem: stimulus queues expectations, a negedge monitor checks them.
module tb_prog_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        read;
  logic        write;
  logic [7:0]  rdata;
  logic        ld_en;
  logic        ld_strobe;
  logic [7:0]  ld_data;
  logic [7:0]  ld_ptr;
  logic [8:0]  ld_count;
  logic        ld_full;
  logic [7:0]  ld_view;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];

  localparam int S_RDATA = 0, S_PTR = 1, S_CNT = 2, S_FULL = 3, S_VIEW = 4;

  prog_mem #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .read(read), .write(write),
    .rdata(rdata), .ld_en(ld_en), .ld_strobe(ld_strobe), .ld_data(ld_data),
    .ld_ptr(ld_ptr), .ld_count(ld_count), .ld_full(ld_full), .ld_view(ld_view)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_RDATA: return {8'h00, rdata};
      S_PTR:   return {8'h00, ld_ptr};
      S_CNT:   return {7'h00, ld_count};
      S_FULL:  return {15'h0, ld_full};
      default: return {8'h00, ld_view};
    endcase
  endfunction

  // Monitor: everything queued since the last edge is compared mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      act = observe(e.sel);
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s actual=%h expected=%h", e.name, act, e.exp);
      end else begin
        $display("ok   %s = %h", e.name, act);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [15:0] exp, input string name);
    exp_t e;
    e.sel = sel; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] d);
    ld_data = d; ld_strobe = 1'b1;
    step();
    ld_strobe = 1'b0;
    step();
  endtask

  task automatic chk_read(input logic [15:0] a, input logic [7:0] exp, input string name);
    addr = a; read = 1'b1;
    expect_val(S_RDATA, {8'h00, exp}, name);
    step();
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; read = 1'b0; write = 1'b0;
    ld_en = 1'b0; ld_strobe = 1'b0; ld_data = '0;
    step(); step();
    expect_val(S_PTR, 16'd0, "reset_ptr");
    expect_val(S_CNT, 16'd0, "reset_count");
    expect_val(S_FULL, 16'd0, "reset_full");
    expect_val(S_RDATA, 16'd0, "reset_rdata_noread");
    step();
    rst = 1'b0;
    step();

    // Enter load mode and load three bytes.
    ld_en = 1'b1;
    step();
    expect_val(S_PTR, 16'd0, "enter_ptr");
    expect_val(S_CNT, 16'd0, "enter_count");
    pulse(8'hA5); pulse(8'h3C); pulse(8'hFF);
    expect_val(S_PTR, 16'd3, "load3_ptr");
    expect_val(S_CNT, 16'd3, "load3_count");
    expect_val(S_FULL, 16'd0, "load3_full");
    ld_en = 1'b0;
    step();
    chk_read(16'h0001, 8'h3C, "read_a1");
    chk_read(16'hFF01, 8'h3C, "read_alias_ff01");
    chk_read(16'h0000, 8'hA5, "read_a0");
    chk_read(16'h0002, 8'hFF, "read_a2");
    expect_val(S_PTR, 16'd3, "idle_retain_ptr");
    expect_val(S_CNT, 16'd3, "idle_retain_count");
    step();

    // Strobe held high across entry into WAIT: nothing written until released.
    ld_strobe = 1'b1; ld_data = 8'h11;
    step();
    ld_en = 1'b1;
    step();
    repeat (10) step();
    expect_val(S_CNT, 16'd0, "held_entry_count");
    expect_val(S_PTR, 16'd0, "held_entry_ptr");
    ld_strobe = 1'b0;
    step();
    pulse(8'h22);
    ld_data = 8'h33; ld_strobe = 1'b1;
    repeat (5) step();
    expect_val(S_CNT, 16'd2, "long_pulse_count");
    ld_strobe = 1'b0;
    step();
    ld_en = 1'b0;
    step();
    expect_val(S_VIEW, 16'h00FF, "view_ptr2");
    chk_read(16'h0000, 8'h22, "held_read_a0");
    chk_read(16'h0001, 8'h33, "held_read_a1");
    chk_read(16'h0002, 8'hFF, "held_read_a2");

    // CPU writes, blocked writes in load mode, read-during-write.
    read = 1'b0; write = 1'b1; addr = 16'h0005; wdata = 8'h55;
    expect_val(S_RDATA, 16'h0000, "noread_rdata");
    step();
    write = 1'b0;
    chk_read(16'h0005, 8'h55, "cpu_write_55");
    ld_en = 1'b1; write = 1'b1; wdata = 8'h77;
    expect_val(S_RDATA, 16'h0000, "lden_rdata_zero");
    step();
    ld_en = 1'b0; write = 1'b0;
    chk_read(16'h0005, 8'h55, "blocked_write_a5");
    write = 1'b1; wdata = 8'h77;
    step();
    write = 1'b0;
    chk_read(16'h0005, 8'h77, "cpu_write_77");
    read = 1'b0;
    expect_val(S_RDATA, 16'h0000, "read0_rdata");
    step();
    write = 1'b1; addr = 16'h0006; wdata = 8'h12;
    step();
    write = 1'b1; read = 1'b1; wdata = 8'h99;
    expect_val(S_RDATA, 16'h0012, "rw_old_value");
    step();
    write = 1'b0;
    chk_read(16'h0006, 8'h99, "rw_new_value");
    read = 1'b0;

    // Fill all 256 bytes with d(i) = 3*i + 7.
    ld_en = 1'b1;
    step();
    for (int i = 0; i < 255; i++) pulse(8'(3 * i + 7));
    expect_val(S_FULL, 16'd0, "fill255_full");
    expect_val(S_CNT, 16'd255, "fill255_count");
    pulse(8'h04);
    expect_val(S_FULL, 16'd1, "fill256_full");
    expect_val(S_CNT, 16'd256, "fill256_count");
    expect_val(S_PTR, 16'd0, "fill256_ptr_wrap");
    expect_val(S_VIEW, 16'h0007, "fill256_view0");
    step();
    pulse(8'hEE);
    expect_val(S_VIEW, 16'h0007, "extra_strobe_view0");
    expect_val(S_CNT, 16'd256, "extra_strobe_count");
    step();
    ld_en = 1'b0;
    step();
    expect_val(S_FULL, 16'd1, "idle_retain_full");
    chk_read(16'h0000, 8'h07, "fill_read_a0");
    chk_read(16'h0080, 8'h87, "fill_read_a128");
    chk_read(16'h00FF, 8'h04, "fill_read_a255");
    read = 1'b0;

    // Reset while in HOLD with load mode still on.
    ld_en = 1'b1;
    step();
    pulse(8'hC1);
    ld_data = 8'hC2; ld_strobe = 1'b1;
    step();
    expect_val(S_PTR, 16'd2, "hold_ptr");
    step();
    rst = 1'b1;
    step();
    expect_val(S_PTR, 16'd0, "midrst_ptr");
    expect_val(S_CNT, 16'd0, "midrst_count");
    rst = 1'b0;
    step();
    expect_val(S_PTR, 16'd0, "restart_ptr");
    expect_val(S_FULL, 16'd0, "restart_full");
    expect_val(S_VIEW, 16'h00C1, "restart_view0");
    step();
    ld_strobe = 1'b0; ld_en = 1'b0;
    step();
    chk_read(16'h0001, 8'hC2, "midrst_read_a1");
    chk_read(16'h0002, 8'h0D, "midrst_read_a2");
    read = 1'b0;

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached=1 expected=0");
    $fatal(1, "timeout");
  end
endmodule
